// File: rtl/imem_sram.sv
// imem_sram: instruction SRAM with one fetch port and a backdoor word-load port; IMEM_RAND_DELAY_EN adds a random 0..7 extra cycles.
// Latency: resp_valid rises D cycles after the request handshake (D = LAT, or LAT + lfsr[2:0] with IMEM_RAND_DELAY_EN).
// Backpressure: one request in flight; resp_valid holds with stable data until resp_ready, and req_ready returns the cycle after.
module imem_sram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LAT        = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = 5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [31:0]           addr_q;
  logic [CW-1:0]         dly;
  logic [31:0]           mem [0:DEPTH-1];

  logic [31:0]           sel_addr;
  logic [31:0]           off;
  logic [31:0]           word;
  logic                  lk_err;
  logic [DEPTH_LOG2-1:0] lk_idx;
  logic [31:0]           lk_data;

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign dly = CW'(LAT) + CW'(lfsr[2:0]);
`else
  assign dly = CW'(LAT);
`endif

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // RESP is entered either straight from IDLE (D=1, address still on the port) or from WAIT (captured address).
  always_comb begin
    sel_addr = (state == IDLE) ? req_addr : addr_q;
    off      = sel_addr - BASE_ADDR;
    word     = off >> 2;
    lk_err   = (sel_addr[1:0] != 2'b00) || ((word >> DEPTH_LOG2) != 32'd0);
    lk_idx   = word[DEPTH_LOG2-1:0];
    lk_data  = (load_en && (load_addr == lk_idx)) ? load_data : mem[lk_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      cnt        <= '0;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (dly == CW'(1)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= lk_err ? 32'h0 : lk_data;
              resp_err   <= lk_err;
            end else begin
              state <= WAIT;
              cnt   <= dly - CW'(1);
            end
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            state      <= RESP;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_data  <= lk_err ? 32'h0 : lk_data;
            resp_err   <= lk_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_ready && resp_valid));

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_err)));

endmodule

// File: tb/tb_imem_sram.sv
// tb_imem_sram: drives two imem_sram instances (LAT=1 and LAT=3) with directed and random fetches,
// checking each against a word-array/latency reference model held in the bench.
`timescale 1ns/1ps
module tb_imem_sram;

  localparam int          DL    = 10;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT0  = 1;
  localparam int          LAT1  = 3;
`ifdef IMEM_RAND_DELAY_EN
  localparam bit RAND = 1'b1;
`else
  localparam bit RAND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid  [2];
  logic          req_ready  [2];
  logic [31:0]   req_addr   [2];
  logic          resp_valid [2];
  logic          resp_ready [2];
  logic [31:0]   resp_data  [2];
  logic          resp_err   [2];
  logic          load_en    [2];
  logic [DL-1:0] load_addr  [2];
  logic [31:0]   load_data  [2];

  logic [31:0]   shadow [2][DEPTH];
  int            cyc;
  int            n_chk = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  imem_sram #(.DEPTH_LOG2(DL), .LAT(LAT0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  imem_sram #(.DEPTH_LOG2(DL), .LAT(LAT1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  // Clock edges seen since reset release; the random-delay state is the seed stepped this many times.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    logic [31:0] offs;
    offs = a - BASE;
    return ((a % 4) != 0) || ((offs / 4) >= DEPTH);
  endfunction

  task automatic step(input int k, output bit loaded);
    @(posedge clk); #1;
    loaded = load_en[k];
    if (load_en[k]) begin
      shadow[k][load_addr[k]] = load_data[k];
      load_en[k] = 1'b0;
    end
  endtask

  task automatic load_word(input int k, input int idx, input logic [31:0] d);
    bit ld;
    @(negedge clk);
    load_en[k] = 1'b1; load_addr[k] = DL'(idx); load_data[k] = d;
    step(k, ld);
  endtask

  // lm: 0 no load, 1 load pending word on the RESP-entry edge, 2 load it after RESP entry.
  task automatic do_req(input int k, input logic [31:0] a, input int hold, input int lm_in, input bit junk);
    int          d, lm, widx;
    logic        e;
    logic [31:0] exp_d, nv;
    logic [7:0]  l;
    bit          ld;
    e    = model_err(a);
    lm   = e ? 0 : lm_in;
    widx = e ? 0 : int'((a - BASE) / 4);
    nv   = $urandom;
    @(negedge clk);
    l     = lfsr_after(cyc);
    d     = lat_of(k) + (RAND ? int'(l[2:0]) : 0);
    exp_d = e ? 32'h0 : shadow[k][widx];
    chk("idle_req_ready", req_ready[k], 1);
    req_valid[k]  = 1'b1;
    req_addr[k]   = a;
    resp_ready[k] = (hold == 0);
    if (lm == 1 && d == 1) begin
      load_en[k] = 1'b1; load_addr[k] = DL'(widx); load_data[k] = nv;
    end
    step(k, ld);
    if (ld && lm == 1) exp_d = nv;
    req_valid[k] = junk;
    req_addr[k]  = BASE + 4 * $urandom_range(0, 63);
    for (int j = 1; j < d; j++) begin
      chk("wait_resp_valid", resp_valid[k], 0);
      chk("wait_req_ready", req_ready[k], 0);
      if (lm == 1 && j == d - 1) begin
        load_en[k] = 1'b1; load_addr[k] = DL'(widx); load_data[k] = nv;
      end
      step(k, ld);
      if (ld && lm == 1) exp_d = nv;
    end
    chk("resp_valid", resp_valid[k], 1);
    chk("resp_data", resp_data[k], exp_d);
    chk("resp_err", resp_err[k], e);
    chk("resp_req_ready", req_ready[k], 0);
    if (lm == 2) begin
      load_en[k] = 1'b1; load_addr[k] = DL'(widx); load_data[k] = nv;
    end
    for (int h = 0; h < hold; h++) begin
      step(k, ld);
      chk("hold_resp_valid", resp_valid[k], 1);
      chk("hold_resp_data", resp_data[k], exp_d);
      chk("hold_resp_err", resp_err[k], e);
      chk("hold_req_ready", req_ready[k], 0);
    end
    resp_ready[k] = 1'b1;
    step(k, ld);
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b0;
    chk("done_resp_valid", resp_valid[k], 0);
    chk("done_req_ready", req_ready[k], 1);
  endtask

  task automatic reset_in_wait();
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd4; resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("pre_rst_req_ready", req_ready[1], 0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_resp_valid", resp_valid[k], 0);
      chk("rst_resp_data", resp_data[k], 0);
      chk("rst_resp_err", resp_err[k], 0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready[1], 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", resp_valid[1], 0);
    end
    resp_ready[1] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          k, r;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b0;
      load_en[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_resp_valid", resp_valid[i], 0);
      chk("reset_resp_data", resp_data[i], 0);
      chk("reset_resp_err", resp_err[i], 0);
    end
    rst_n = 1'b1;
    #1;
    chk("release_req_ready0", req_ready[0], 1);
    chk("release_req_ready1", req_ready[1], 1);

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) load_word(i, w, $urandom);
      load_word(i, DEPTH - 1, $urandom);
    end
    load_word(0, 0, 32'h0000_0413);
    load_word(1, 1, 32'hDEAD_BEEF);

    do_req(0, 32'h8000_0000, 0, 0, 0);
    do_req(1, 32'h8000_0004, 4, 0, 1);
    for (int i = 0; i < 2; i++) begin
      do_req(i, 32'h8000_0002, 1, 0, 0);
      do_req(i, 32'h8000_1000, 0, 0, 0);
      do_req(i, 32'h7FFF_FFFC, 0, 0, 0);
      do_req(i, 32'h8000_0FFC, 0, 0, 0);
      do_req(i, 32'h8000_0FFD, 0, 0, 0);
      do_req(i, 32'h8000_0008, 1, 1, 0);
      do_req(i, 32'h8000_0008, 0, 0, 0);
      do_req(i, 32'h8000_000C, 2, 2, 0);
      do_req(i, 32'h8000_000C, 0, 0, 0);
    end
    do_req(1, 32'h8000_0004, 0, 0, 0);

    reset_in_wait();
    do_req(1, 32'h8000_0004, 1, 0, 0);
    do_req(0, 32'h8000_0000, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      k = int'($urandom % 2);
      r = int'($urandom % 10);
      case (r)
        0:       a = BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
        1:       a = BASE + 4 * (DEPTH + $urandom_range(0, 5000));
        2:       a = BASE - 4 * $urandom_range(1, 1000);
        3:       a = BASE + 4 * (DEPTH - 1);
        default: a = BASE + 4 * $urandom_range(0, 63);
      endcase
      do_req(k, a, int'($urandom % 4), int'($urandom % 3), 1'($urandom % 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
